// File: rtl/score_pkg.sv
// Shared types and sizes for the score reader.
package score_pkg;

    localparam int unsigned SCORE_W    = 16;
    localparam int unsigned BCD_DIGITS = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/dabble_adjust.sv
// Double-dabble nibble correction: digits of 5 or more get +3 before the shift.
module dabble_adjust (
    input  logic [3:0] nibble,
    output logic [3:0] adj_c
);

    // A nibble here never exceeds 9, so the 4-bit add cannot overflow.
    assign adj_c = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/score_reader.sv
// Sequential binary-to-BCD reader for the game score, plus an optional
// high-score capture built only when HIGH_SCORE_EN is defined.
module score_reader
    import score_pkg::*;
#(
    parameter int unsigned W      = SCORE_W,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic                  clkout,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [W-1:0]          score,
    input  logic                  collision,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [W-1:0]          high_score
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + W;
    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_next_c;
    logic [BCD_W-1:0]  adj_c;
    logic [CNT_W-1:0]  cnt;

    // Correct every BCD digit in parallel, then shift the whole register.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        dabble_adjust u_adj (
            .nibble (sr[W + 4*d +: 4]),
            .adj_c  (adj_c[4*d +: 4])
        );
    end

    assign sr_next_c = {adj_c, sr[W-1:0]} << 1;

    // Conversion FSM; score is captured only on the accepting edge.
    always_ff @(posedge clkout or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {BCD_W'(0), score};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next_c;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(W - 1)) begin
                        bcd   <= sr_next_c[SR_W-1 -: BCD_W];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HIGH_SCORE_EN
    logic collision_q;

    // Capture on the rising edge of collision only; a held level does not retrigger.
    always_ff @(posedge clkout or negedge resetn) begin
        if (!resetn) begin
            collision_q <= 1'b0;
            high_score  <= '0;
        end else begin
            collision_q <= collision;
            if (collision && !collision_q && (score > high_score)) begin
                high_score <= score;
            end
        end
    end
`else
    logic unused_collision;

    assign unused_collision = collision;
    assign high_score       = '0;
`endif

endmodule
